seq_mult_param: RTL

//  Parametrised multi-cycle multiplier: WIDTH x WIDTH -> 2*WIDTH using one DIGIT x DIGIT

---
 rtl/seq_mult_param.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_mult_param.sv
// Multi-cycle WIDTH x WIDTH multiplier built from one DIGIT x DIGIT partial-product
// multiplier, with signed/unsigned mode and a fixed latency of NUM*NUM+2 cycles.
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_md,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   d_out,
  output logic                 busy,
  output logic                 done_flag,
  output logic [2:0]           state
);

  localparam int NUM = WIDTH / DIGIT;
  localparam int AW  = 2 * WIDTH;
  localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_SIGN = 3'd2,
    S_DONE = 3'd3
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_neg;
  logic [AW-1:0]       r_acc;
  logic [AW-1:0]       r_dout;
  logic [CW-1:0]       r_i;
  logic [CW-1:0]       r_j;
  logic                r_busy;
  logic                r_done;

  logic [DIGIT-1:0]    w_adig;
  logic [DIGIT-1:0]    w_bdig;
  logic [2*DIGIT-1:0]  w_prod;
  logic [AW-1:0]       w_pp;

  // Magnitude of the most negative operand still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic sgn);
    logic signed [WIDTH-1:0] sx;
    sx = signed'(x);
    return (sgn && sx[WIDTH-1]) ? -sx : x;
  endfunction

  function automatic logic [AW-1:0] f_apply_sign(input logic [AW-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  assign w_adig = r_a[r_i*DIGIT +: DIGIT];
  assign w_bdig = r_b[r_j*DIGIT +: DIGIT];
  assign w_prod = {{DIGIT{1'b0}}, w_adig} * {{DIGIT{1'b0}}, w_bdig};
  assign w_pp   = AW'(w_prod) << (DIGIT * (int'(r_i) + int'(r_j)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_dout  <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= f_mag(a, signed_md);
            r_b     <= f_mag(b, signed_md);
            r_neg   <= signed_md & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MULT;
          end
        end
        // j walks the multiplier digits; i advances on each j wrap
        S_MULT: begin
          r_acc <= r_acc + w_pp;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) begin
              r_i     <= '0;
              r_state <= S_SIGN;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_SIGN: begin
          r_dout  <= f_apply_sign(r_acc, r_neg);
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign d_out     = r_dout;
  assign busy      = r_busy;
  assign done_flag = r_done;
  assign state     = r_state;

endmodule
